// File: rtl/prbs9_checker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prbs_pkg
//  Description : Shared PRBS-9 constants, checker state encoding and the
//                XNOR next-bit prediction used by the PRBS-9 checker.
//  Revision    : 1.0  initial release
// ============================================================================
package prbs_pkg;

  localparam int LFSR_W = 9;
  localparam int TAP_A  = 0;
  localparam int TAP_B  = 4;

  // All-ones is the XNOR LFSR lock-up state; a stuck-high line also lands here.
  localparam logic [LFSR_W-1:0] LOCKUP = 9'h1FF;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Next stream bit implied by the last nine bits (hist[0] oldest).
  function automatic logic prbs9_pred(input logic [LFSR_W-1:0] hist);
    return ~(hist[TAP_A] ^ hist[TAP_B]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/prbs9_checker_if.sv
`default_nettype none
// ============================================================================
//  Module      : prbs9_checker_if
//  Description : Receive stream and status bundle of the PRBS-9 checker.
//                master = stream source / status reader, slave = checker.
//  Revision    : 1.0  initial release
// ============================================================================
interface prbs9_checker_if #(
  parameter int CNT_W = 16
);
  logic             rx_valid;
  logic             rx_bit;
  logic             clear_cnt;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] bit_count;

  modport master (
    output rx_valid, rx_bit, clear_cnt,
    input  locked, err_pulse, err_count, bit_count
  );

  modport slave (
    input  rx_valid, rx_bit, clear_cnt,
    output locked, err_pulse, err_count, bit_count
  );
endinterface
`default_nettype wire

// File: rtl/prbs9_checker_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at all-ones; synchronous clear wins
//                over increment.
//  Revision    : 1.0  initial release
// ============================================================================
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             inc,
  input  wire logic             clr,
  output logic      [CNT_W-1:0] q
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Count register: clear first, then increment unless already saturated.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {CNT_W{1'b1}})) begin
      q <= q + ONE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/prbs9_checker.sv
`default_nettype none
// ============================================================================
//  Module      : prbs9_checker
//  Description : Self-synchronising PRBS-9 (x^9+x^5, XNOR) stream checker.
//                Fills a 9-bit history, verifies predictions until a clean
//                run is seen, then flywheels on its own prediction so each
//                flipped line bit costs exactly one error.
//  Revision    : 1.0  initial release
// ============================================================================
module prbs9_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_THRESH = 16,
  parameter int LOSS_THRESH = 4,
  parameter int GOOD_CLR    = 8,
  parameter int CNT_W       = 16
) (
  input wire logic          clk,
  input wire logic          reset,
  prbs9_checker_if.slave    bus
);

  localparam int RUN_W  = $clog2(LOCK_THRESH + 1);
  localparam int BAD_W  = $clog2(LOSS_THRESH + 1);
  localparam int GOOD_W = $clog2(GOOD_CLR + 1);
  localparam int FILL_W = $clog2(LFSR_W + 1);

  localparam logic [RUN_W-1:0]  RUN_TOP   = RUN_W'(LOCK_THRESH);
  localparam logic [BAD_W-1:0]  BAD_TOP   = BAD_W'(LOSS_THRESH);
  localparam logic [GOOD_W-1:0] GOOD_TOP  = GOOD_W'(GOOD_CLR);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(LFSR_W - 1);

  state_t              state,     state_n;
  logic [LFSR_W-1:0]   hist,      hist_n;
  logic [FILL_W-1:0]   fill_cnt,  fill_n;
  logic [RUN_W-1:0]    run_cnt,   run_n;
  logic [BAD_W-1:0]    bad_cnt,   bad_n;
  logic [GOOD_W-1:0]   good_cnt,  good_n;
  logic                err_pulse_q, err_pulse_n;
  logic                pred;
  logic                mismatch;
  logic                err_inc;
  logic                bit_inc;

  // State and datapath registers; idle beats hold everything via the defaults below.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FILL;
      hist        <= '0;
      fill_cnt    <= '0;
      run_cnt     <= '0;
      bad_cnt     <= '0;
      good_cnt    <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state       <= state_n;
      hist        <= hist_n;
      fill_cnt    <= fill_n;
      run_cnt     <= run_n;
      bad_cnt     <= bad_n;
      good_cnt    <= good_n;
      err_pulse_q <= err_pulse_n;
    end
  end

  // Next-state, history shift and counter updates for one received beat.
  always_comb begin
    pred        = prbs9_pred(hist);
    mismatch    = (bus.rx_bit != pred);
    state_n     = state;
    hist_n      = hist;
    fill_n      = fill_cnt;
    run_n       = run_cnt;
    bad_n       = bad_cnt;
    good_n      = good_cnt;
    err_pulse_n = 1'b0;
    err_inc     = 1'b0;
    bit_inc     = 1'b0;

    if (bus.rx_valid) begin
      case (state)
        FILL: begin
          hist_n = {bus.rx_bit, hist[LFSR_W-1:1]};
          if (fill_cnt == FILL_LAST) begin
            state_n = VERIFY;
            fill_n  = '0;
            run_n   = '0;
          end else begin
            fill_n = fill_cnt + FILL_W'(1);
          end
        end

        VERIFY: begin
          // Keep resynchronising on the line bit until the run is long enough.
          hist_n = {bus.rx_bit, hist[LFSR_W-1:1]};
          if (mismatch || (hist == LOCKUP)) begin
            run_n = '0;
          end else begin
            run_n = run_cnt + RUN_W'(1);
          end
          if (run_n == RUN_TOP) begin
            state_n = LOCKED;
            run_n   = '0;
            bad_n   = '0;
            good_n  = '0;
          end
        end

        LOCKED: begin
          // Flywheel: feed our own prediction back so line errors do not propagate.
          hist_n  = {pred, hist[LFSR_W-1:1]};
          bit_inc = 1'b1;
          if (mismatch) begin
            err_pulse_n = 1'b1;
            err_inc     = 1'b1;
            bad_n       = bad_cnt + BAD_W'(1);
            good_n      = '0;
          end else begin
            good_n = good_cnt + GOOD_W'(1);
            if (good_n == GOOD_TOP) begin
              good_n = '0;
              bad_n  = '0;
            end
          end
          if (bad_n == BAD_TOP) begin
            state_n = FILL;
            hist_n  = '0;
            fill_n  = '0;
            run_n   = '0;
            bad_n   = '0;
            good_n  = '0;
          end
        end

        default: begin
          state_n = FILL;
        end
      endcase
    end
  end

  assign bus.locked    = (state == LOCKED);
  assign bus.err_pulse = err_pulse_q;

  sat_counter #(.CNT_W(CNT_W)) u_err_count (
    .clk   (clk),
    .reset (reset),
    .inc   (err_inc),
    .clr   (bus.clear_cnt),
    .q     (bus.err_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bit_count (
    .clk   (clk),
    .reset (reset),
    .inc   (bit_inc),
    .clr   (bus.clear_cnt),
    .q     (bus.bit_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_prbs9_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prbs9_checker
//  Description : Directed bench for prbs9_checker driven by a golden PRBS-9
//                generator (seed 9'h000, b[n+9] = b[n] XNOR b[n+4]).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_prbs9_checker;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [8:0] gen = 9'h000;
  int n_assert = 0;
  int n_fail = 0;
  logic seen_lock;

  prbs9_checker_if #(.CNT_W(16)) bus ();

  prbs9_checker dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One valid beat of the golden stream, optionally inverted; ends #1 after the edge.
  task automatic beat(input logic flip);
    bus.rx_valid = 1'b1;
    bus.rx_bit   = gen[0] ^ flip;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    gen = {~(gen[0] ^ gen[4]), gen[8:1]};
  endtask

  task automatic beats(input int n);
    for (int i = 0; i < n; i++) beat(1'b0);
  endtask

  task automatic raw_beat(input logic b);
    bus.rx_valid = 1'b1;
    bus.rx_bit   = b;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    gen = 9'h000;
  endtask

  initial begin
    bus.rx_valid  = 1'b0;
    bus.rx_bit    = 1'b0;
    bus.clear_cnt = 1'b0;
    idle(2);
    chk("reset_locked", bus.locked, 0);
    chk("reset_err_pulse", bus.err_pulse, 0);
    chk("reset_err_count", bus.err_count, 0);
    chk("reset_bit_count", bus.bit_count, 0);
    do_reset();

    // 1: clean acquisition, lock exactly after beat 25
    beats(24);
    chk("t1_not_locked_24", bus.locked, 0);
    beat(1'b0);
    chk("t1_locked_25", bus.locked, 1);
    chk("t1_err_count", bus.err_count, 0);
    chk("t1_bit_count", bus.bit_count, 0);

    // 2: single flipped bit while locked
    beats(3);
    chk("t2_bit_count_3", bus.bit_count, 3);
    beat(1'b1);
    chk("t2_err_pulse", bus.err_pulse, 1);
    chk("t2_err_count", bus.err_count, 1);
    chk("t2_locked", bus.locked, 1);
    beat(1'b0);
    chk("t2_pulse_gone", bus.err_pulse, 0);
    beats(10);
    chk("t2_err_count_after", bus.err_count, 1);
    chk("t2_bit_count", bus.bit_count, 15);
    chk("t2_still_locked", bus.locked, 1);

    // 3: four errors within six beats drop lock, then relock
    beat(1'b1); beat(1'b0); beat(1'b1); beat(1'b0); beat(1'b1);
    chk("t3_locked_after_3_errs", bus.locked, 1);
    beat(1'b1);
    chk("t3_lost_lock", bus.locked, 0);
    chk("t3_err_count", bus.err_count, 5);
    chk("t3_bit_count", bus.bit_count, 21);
    beats(24);
    chk("t3_not_relocked_24", bus.locked, 0);
    beat(1'b0);
    chk("t3_relocked", bus.locked, 1);
    chk("t3_bit_count_held", bus.bit_count, 21);
    chk("t3_err_count_held", bus.err_count, 5);

    // 4: stuck-at lines never lock
    do_reset();
    seen_lock = 1'b0;
    for (int i = 0; i < 200; i++) begin
      raw_beat(1'b1);
      seen_lock = seen_lock | bus.locked;
    end
    chk("t4_stuck1_no_lock", seen_lock, 0);
    do_reset();
    seen_lock = 1'b0;
    for (int i = 0; i < 200; i++) begin
      raw_beat(1'b0);
      seen_lock = seen_lock | bus.locked;
    end
    chk("t4_stuck0_no_lock", seen_lock, 0);

    // 5: rx_valid every other cycle
    do_reset();
    for (int i = 0; i < 24; i++) begin
      beat(1'b0);
      idle(1);
    end
    chk("t5_not_locked_24", bus.locked, 0);
    beat(1'b0);
    chk("t5_locked_25", bus.locked, 1);
    idle(3);
    chk("t5_idle_locked", bus.locked, 1);
    chk("t5_idle_bit_count", bus.bit_count, 0);
    for (int i = 0; i < 5; i++) begin
      beat(1'b0);
      idle(1);
    end
    chk("t5_bit_count_5", bus.bit_count, 5);
    chk("t5_err_count_0", bus.err_count, 0);

    // 6: clear_cnt with a same-cycle error, then reset while locked
    bus.clear_cnt = 1'b1;
    beat(1'b1);
    bus.clear_cnt = 1'b0;
    chk("t6_clr_err_pulse", bus.err_pulse, 1);
    chk("t6_clr_err_count", bus.err_count, 0);
    chk("t6_clr_bit_count", bus.bit_count, 0);
    beats(2);
    beat(1'b1);
    chk("t6_err_count_1", bus.err_count, 1);
    reset = 1'b1;
    #1;
    chk("t6_async_locked", bus.locked, 0);
    chk("t6_async_err_pulse", bus.err_pulse, 0);
    chk("t6_async_err_count", bus.err_count, 0);
    chk("t6_async_bit_count", bus.bit_count, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    beats(24);
    chk("t6_not_relocked_24", bus.locked, 0);
    beat(1'b0);
    chk("t6_relocked", bus.locked, 1);
    chk("t6_relock_err_count", bus.err_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
